// File: rtl/tick_pkg.sv
// ============================================================================
// Module   : tick_pkg
// Brief    : Clock constants and named divisors for the tick generators.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_pkg;

    localparam int unsigned CLK_HZ = 100000000;

    function automatic int unsigned HZ_TO_DIV(input int unsigned f);
        return CLK_HZ / f;
    endfunction

    localparam int unsigned DIV_1HZ  = HZ_TO_DIV(1);
    localparam int unsigned DIV_2HZ  = HZ_TO_DIV(2);
    localparam int unsigned DIV_1KHZ = HZ_TO_DIV(1000);

endpackage

`default_nettype wire

// File: rtl/tick_channel.sv
// ============================================================================
// Module   : tick_channel
// Brief    : One divider channel with a shadowed divisor, tick pulse and square wave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_channel #(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(100000000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             tick,
    output logic             sq,
    output logic             busy_upd
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_tick;
    logic             r_sq;
    logic             r_busy;

    logic [CNT_W-1:0] w_div_eff;
    logic [CNT_W-1:0] w_term;
    logic             w_wrap;

    // A zero divisor behaves as one; >= makes a lowered divisor wrap at once.
    assign w_div_eff = (r_div == '0) ? c_one : r_div;
    assign w_term    = w_div_eff - c_one;
    assign w_wrap    = en && (r_cnt >= w_term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= DEFAULT_DIV;
            r_shadow <= DEFAULT_DIV;
            r_tick   <= 1'b0;
            r_sq     <= 1'b0;
            r_busy   <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
            if (r_busy) begin
                r_div <= r_shadow;
            end
            r_busy <= 1'b0;
            if (div_load) begin
                r_shadow <= div_in;
                r_busy   <= 1'b1;
            end
        end else begin
            r_tick <= w_wrap;
            if (w_wrap) begin
                r_cnt <= '0;
                r_sq  <= ~r_sq;
                if (r_busy) begin
                    r_div  <= r_shadow;
                    r_busy <= 1'b0;
                end
            end else if (en) begin
                r_cnt <= r_cnt + c_one;
            end
            // A load on a wrap edge becomes the next pending value only.
            if (div_load) begin
                r_shadow <= div_in;
                r_busy   <= 1'b1;
            end
        end
    end

    assign tick     = r_tick;
    assign sq       = r_sq;
    assign busy_upd = r_busy;

endmodule

`default_nettype wire

// File: rtl/multi_tick_gen.sv
// ============================================================================
// Module   : multi_tick_gen
// Brief    : Multi-channel programmable tick and square-wave generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_tick_gen
    import tick_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clear,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq,
    output logic [NUM_CH-1:0]       busy_upd
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (c_default_div)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clear    (clear),
            .div_in   (div_in[c*CNT_W +: CNT_W]),
            .div_load (div_load[c]),
            .tick     (tick[c]),
            .sq       (sq[c]),
            .busy_upd (busy_upd[c])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_tick_gen.sv
// ============================================================================
// Module   : tb_multi_tick_gen
// Brief    : Directed self-checking bench for multi_tick_gen (2 ch, 8-bit, div 5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clear;
    logic [15:0] div_in;
    logic [1:0]  div_load;
    logic [1:0]  tick;
    logic [1:0]  sq;
    logic [1:0]  busy_upd;

    int tests  = 0;
    int failed = 0;

    multi_tick_gen #(
        .NUM_CH      (2),
        .CNT_W       (8),
        .DEFAULT_DIV (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (clear),
        .div_in   (div_in),
        .div_load (div_load),
        .tick     (tick),
        .sq       (sq),
        .busy_upd (busy_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One active edge, then sample on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; div_in = '0; div_load = '0;
        repeat (3) @(negedge clk);
        check("rst_tick", 32'(tick), 0);
        check("rst_sq", 32'(sq), 0);
        check("rst_busy", 32'(busy_upd), 0);

        // Default period on ch0; ch1 gets divisor 3 loaded at edge 2.
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            if (k == 2) begin
                div_load = 2'b10; div_in[15:8] = 8'd3;
            end
            cyc();
            div_load = '0;
            check("t1_tick0", 32'(tick[0]), 32'(k % 5 == 0));
            check("t1_sq0", 32'(sq[0]), 32'((k / 5) % 2));
            check("t2_tick1", 32'(tick[1]), 32'(k == 5 || k == 8 || k == 11 || k == 14));
            check("t2_busy1", 32'(busy_upd[1]), 32'(k >= 2 && k < 5));
            check("t2_sq1", 32'(sq[1]), 32'((k >= 5 && k < 8) || (k >= 11 && k < 14)));
        end

        // Freeze ch0 at cnt=2 for 7 cycles.
        cyc(); cyc();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check("t3_frz_tick", 32'(tick), 0);
            check("t3_frz_sq0", 32'(sq[0]), 1);
        end
        en = 1'b1;
        cyc(); check("t3_run1", 32'(tick[0]), 0);
        cyc(); check("t3_run2", 32'(tick[0]), 0);
        cyc(); check("t3_tick", 32'(tick[0]), 1);
        check("t3_sq0", 32'(sq[0]), 0);

        // Divisor 1 then 0 on ch0.
        div_in[7:0] = 8'd1; div_load = 2'b01;
        cyc(); div_load = '0;
        check("t4_busy", 32'(busy_upd[0]), 1);
        cyc(); cyc(); cyc();
        cyc();
        check("t4_wrap_tick", 32'(tick[0]), 1);
        check("t4_wrap_busy", 32'(busy_upd[0]), 0);
        check("t4_wrap_sq", 32'(sq[0]), 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t4_d1_tick", 32'(tick[0]), 1);
            check("t4_d1_sq", 32'(sq[0]), 32'(i % 2));
        end
        div_in[7:0] = 8'd0; div_load = 2'b01;
        cyc(); div_load = '0;
        check("t4_d0_busy", 32'(busy_upd[0]), 1);
        check("t4_d0_sq_a", 32'(sq[0]), 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t4_d0_tick", 32'(tick[0]), 1);
            check("t4_d0_sq", 32'(sq[0]), 32'(i % 2));
        end
        check("t4_d0_applied", 32'(busy_upd[0]), 0);

        // Back to 5, then two loads (9 then 7) and a clear at cnt=3.
        div_in[7:0] = 8'd5; div_load = 2'b01;
        cyc(); div_load = '0;
        cyc();
        check("t5_tick_d5", 32'(tick[0]), 1);
        check("t5_busy_d5", 32'(busy_upd[0]), 0);
        div_in[7:0] = 8'd9; div_load = 2'b01;
        cyc();
        check("t5_c1", 32'(tick[0]), 0);
        div_in[7:0] = 8'd7;
        cyc(); div_load = '0;
        cyc();
        check("t5_pend", 32'(busy_upd[0]), 1);
        clear = 1'b1;
        cyc(); clear = 1'b0;
        check("t5_clr_tick", 32'(tick[0]), 0);
        check("t5_clr_sq", 32'(sq[0]), 0);
        check("t5_clr_busy", 32'(busy_upd[0]), 0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("t5_wait", 32'(tick[0]), 0);
        end
        cyc();
        check("t5_tick7", 32'(tick[0]), 1);
        check("t5_sq7", 32'(sq[0]), 1);

        // Async reset at ch0 cnt=4 with a ch1 load pending.
        cyc(); cyc(); cyc();
        div_in[15:8] = 8'd9; div_load = 2'b10;
        cyc(); div_load = '0;
        check("t6_pre_busy1", 32'(busy_upd[1]), 1);
        check("t6_pre_sq0", 32'(sq[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_sq", 32'(sq), 0);
        check("t6_async_busy", 32'(busy_upd), 0);
        check("t6_async_tick", 32'(tick), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("t6_rst_div", 32'(tick), (k == 5) ? 32'd3 : 32'd0);
        end

        // clear and load in the same cycle: load stays pending.
        clear = 1'b1; div_in[7:0] = 8'd2; div_load = 2'b01;
        cyc(); clear = 1'b0; div_load = '0;
        check("t6_cl_busy", 32'(busy_upd), 1);
        check("t6_cl_tick", 32'(tick[0]), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t6_cl_wait", 32'(tick[0]), 0);
        end
        cyc();
        check("t6_cl_tick5", 32'(tick[0]), 1);
        check("t6_cl_apply", 32'(busy_upd[0]), 0);
        cyc();
        check("t6_d2_gap", 32'(tick[0]), 0);
        // Load on the wrap edge of a div-2 period.
        div_in[7:0] = 8'd4; div_load = 2'b01;
        cyc(); div_load = '0;
        check("t6_wl_tick", 32'(tick[0]), 1);
        check("t6_wl_busy", 32'(busy_upd[0]), 1);
        cyc();
        check("t6_wl_gap", 32'(tick[0]), 0);
        cyc();
        check("t6_wl_tick2", 32'(tick[0]), 1);
        check("t6_wl_apply", 32'(busy_upd[0]), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t6_d4_wait", 32'(tick[0]), 0);
        end
        cyc();
        check("t6_d4_tick", 32'(tick[0]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
